// File: rtl/ls295_seq_ctrl.sv
// Sequencer for a negedge-clocked 4-bit ls295-style shift register: turns
// load/shift commands into sr_clk pulses with mode/ser/in set up a full cycle early.
module ls295_seq_ctrl #(
  parameter int SER_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [SER_W-1:0] cmd_ser,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             oe_en,
  output logic             sr_clk,
  output logic             sr_mode,
  output logic             sr_ser,
  output logic [3:0]       sr_in,
  output logic             sr_oe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so a held command waits for the next IDLE cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2, FIN = 2'd3} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic [SER_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [CNT_W-1:0] shift_n, accept_n;
  logic             sr_clk_q, sr_clk_d;
  logic             sr_mode_q, sr_mode_d;
  logic             sr_ser_q, sr_ser_d;
  logic [3:0]       sr_in_q, sr_in_d;
  logic             sr_oe_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    if (int'(cmd_cnt) > SER_W) shift_n = CNT_W'(SER_W);
    else                       shift_n = cmd_cnt;
    accept_n = cmd_op ? shift_n : CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    pat_d     = pat_q;
    n_d       = n_q;
    pulses_d  = pulses_q;
    sr_mode_d = sr_mode_q;
    sr_ser_d  = sr_ser_q;
    sr_in_d   = sr_in_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          data_d   = cmd_data;
          pat_d    = cmd_ser;
          n_d      = accept_n;
          pulses_d = '0;
          if (accept_n == '0) begin
            state_d = FIN;
          end else begin
            state_d   = HI;
            sr_mode_d = ~cmd_op;
            sr_in_d   = cmd_data;
            sr_ser_d  = cmd_ser[0];
          end
        end
      end
      HI: begin
        // The pattern advances as the falling edge is issued, so bit 0 is next on re-entry to HI.
        state_d  = LO;
        pulses_d = pulses_q + CNT_W'(1);
        pat_d    = pat_q >> 1;
      end
      LO: begin
        if (pulses_q == n_q) begin
          state_d = FIN;
        end else begin
          state_d   = HI;
          sr_mode_d = ~op_q;
          sr_in_d   = data_q;
          sr_ser_d  = pat_q[0];
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sr_clk_d = (state_d != LO);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      data_q    <= '0;
      pat_q     <= '0;
      n_q       <= '0;
      pulses_q  <= '0;
      sr_clk_q  <= 1'b1;
      sr_mode_q <= 1'b0;
      sr_ser_q  <= 1'b0;
      sr_in_q   <= '0;
      sr_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      pat_q     <= pat_d;
      n_q       <= n_d;
      pulses_q  <= pulses_d;
      sr_clk_q  <= sr_clk_d;
      sr_mode_q <= sr_mode_d;
      sr_ser_q  <= sr_ser_d;
      sr_in_q   <= sr_in_d;
      sr_oe_q   <= oe_en;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign sr_clk    = sr_clk_q;
  assign sr_mode   = sr_mode_q;
  assign sr_ser    = sr_ser_q;
  assign sr_in     = sr_in_q;
  assign sr_oe     = sr_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulses    = pulses_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ls295_seq_ctrl.sv
// Bench for ls295_seq_ctrl: randomized commands, a behavioural ls295 register model,
// and a done-driven scoreboard fed from an expected queue at each accept.
module tb_ls295_seq_ctrl;

  localparam int SER_W = 8;
  localparam int CNT_W = 4;
  localparam int W     = 21; // {load_mode, n[3:0], ser[7:0], reg_after[3:0], data[3:0]}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_op = 1'b0;
  logic [3:0]       cmd_data = '0;
  logic [SER_W-1:0] cmd_ser = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             oe_en = 1'b0;
  logic             sr_clk, sr_mode, sr_ser, sr_oe, busy, done;
  logic [3:0]       sr_in;
  logic [CNT_W-1:0] pulses;
  logic [1:0]       dbg_state;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           sim_end = 1'b0;
  logic [3:0]   ref_reg = '0;
  logic [3:0]   ttl_q = '0;

  ls295_seq_ctrl #(.SER_W(SER_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ser(cmd_ser), .cmd_cnt(cmd_cnt),
    .oe_en(oe_en), .sr_clk(sr_clk), .sr_mode(sr_mode), .sr_ser(sr_ser),
    .sr_in(sr_in), .sr_oe(sr_oe), .busy(busy), .done(done), .pulses(pulses),
    .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // TTL register: parallel load when mode=1, else shift left with ser into bit 0
  always @(negedge sr_clk) begin
    if (sr_mode) ttl_q <= sr_in;
    else         ttl_q <= {ttl_q[2:0], sr_ser};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present a command (valid stays high afterwards) and record its expectation on accept
  task automatic send(input logic op, input logic [3:0] data, input logic [7:0] ser,
                      input logic [3:0] cnt);
    int  n;
    bit  ok;
    #1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_ser   = ser;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready && !rst) begin
        @(posedge clk);
        n = op ? ((int'(cnt) > SER_W) ? SER_W : int'(cnt)) : 1;
        if (!op) ref_reg = data;
        else for (int i = 0; i < n; i++) ref_reg = {ref_reg[2:0], ser[i]};
        exp_q.push_back({~op, 4'(n), ser, ref_reg, data});
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // oe_en stimulus runs independently of commands
  initial begin
    while (!sim_end) begin
      @(posedge clk);
      #1 oe_en = 1'($urandom_range(0, 1));
    end
  end

  // monitor / scoreboard
  int         edge_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] obs_ser = '0;
  logic [3:0] last_n = '0;
  logic       prev_rst = 1'b1, prev_oe = 1'b0, prev_mode = 1'b0, prev_ser = 1'b0;
  logic [3:0] prev_in = '0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    int           n;
    int           mask;
    if (rst) begin
      edge_cnt = 0;
      busy_cnt = 0;
      obs_ser  = '0;
      last_n   = '0;
    end else begin
      chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      chk("sr_oe_latency", 32'(sr_oe), prev_rst ? 32'd0 : 32'(prev_oe));
      if (!busy) chk("pulses_hold_idle", 32'(pulses), 32'(last_n));
      if (busy) busy_cnt++;
      if (!sr_clk) begin
        if (edge_cnt < 8) obs_ser[edge_cnt] = sr_ser;
        edge_cnt++;
        chk("stable_low", {29'd0, sr_mode, sr_ser, 1'b0} | 32'(sr_in) << 4,
            {29'd0, prev_mode, prev_ser, 1'b0} | 32'(prev_in) << 4);
        if (exp_q.size() == 0) chk("edge_without_cmd", 32'd1, 32'd0);
        else begin
          e = exp_q[0];
          chk("sr_mode", 32'(sr_mode), 32'(e[20]));
          if (e[20]) chk("sr_in_load", 32'(sr_in), 32'(e[3:0]));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_without_cmd", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          n = int'(e[19:16]);
          mask = (1 << n) - 1;
          chk("edge_count", 32'(edge_cnt), 32'(n));
          chk("busy_cycles", 32'(busy_cnt), 32'(2 * n + 1));
          chk("pulses_at_done", 32'(pulses), 32'(n));
          if (n > 0) chk("reg_value", 32'(ttl_q), 32'(e[7:4]));
          if (!e[20]) chk("ser_sequence", 32'(obs_ser) & 32'(mask), 32'(e[15:8]) & 32'(mask));
          last_n = e[19:16];
        end
        edge_cnt = 0;
        busy_cnt = 0;
        obs_ser  = '0;
      end
    end
    prev_rst  = rst;
    prev_oe   = oe_en;
    prev_mode = sr_mode;
    prev_ser  = sr_ser;
    prev_in   = sr_in;
  end

  // main sequence
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sr_clk", 32'(sr_clk), 32'd1);
    chk("rst_outputs", {26'd0, sr_mode, sr_ser, sr_oe, busy, done, cmd_ready}, 32'd1);
    chk("rst_in_pulses", 32'(sr_in) | 32'(pulses) << 4, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // reset aborts a shift of 5 after two falling edges
    send(1'b1, 4'h3, 8'($urandom), 4'd5);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pulses == 4'd2) seen = 1'b1;
    end
    if (!seen) chk("reach_two_pulses", 32'd0, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_sr_clk", 32'(sr_clk), 32'd1);
    chk("abort_state", {29'd0, sr_oe, busy, done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(1'b0, 4'hA, 8'h00, 4'd0);

    // directed: load 9, shift 0110 by 4, zero count, clamped count
    send(1'b0, 4'h9, 8'h00, 4'd0);
    send(1'b1, 4'h0, 8'b0000_0110, 4'd4);
    send(1'b1, 4'h5, 8'($urandom), 4'd0);
    send(1'b1, 4'h0, 8'($urandom), 4'd15);

    // back-to-back with valid held high, alternating load/shift
    for (int i = 0; i < 30; i++)
      send(1'(i % 2), 4'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    #1 cmd_valid = 1'b0;

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    sim_end = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls295_seq_ctrl.md
Name: ls295_seq_ctrl

Overview:
Sequencer that drives one 4-bit parallel-access shift register of the ls295 type (negedge-clocked; mode=1 parallel load, mode=0 shift with ser into bit 0; oe=0 tri-states outputs). It accepts load/shift commands over a valid/ready handshake and generates the register's clock, mode, serial and parallel inputs with guaranteed setup before each falling edge. It reports completion with a one-cycle done pulse. It sits between a system-clocked master and the TTL register model.

Parameters:
SER_W, 8, width of serial pattern register; max bits shifted per command
CNT_W, 4, width of shift count field; counts above SER_W are clamped to SER_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  1  0 = parallel load, 1 = serial shift
cmd_data  input  4  parallel load value
cmd_ser  input  SER_W  serial pattern; bit 0 shifted first
cmd_cnt  input  CNT_W  number of shift pulses for cmd_op=1; ignored for load
oe_en  input  1  requested output-enable level for the register
sr_clk  output  1  register clock; idle high, falling edge = register event
sr_mode  output  1  register mode pin
sr_ser  output  1  register serial input
sr_in  output  4  register parallel inputs
sr_oe  output  1  register output enable (registered copy of oe_en)
busy  output  1  high from accept until done, inclusive
done  output  1  one-cycle pulse after the last falling edge of a command
pulses  output  CNT_W  falling edges issued for the current or most recent command

Behaviour:
- Reset (rst=1 at a rising edge): sr_clk=1, sr_mode=0, sr_ser=0, sr_in=0, sr_oe=0, busy=0, done=0, pulses=0, state=IDLE, cmd_ready=1 on the following cycle. Reset overrides all else.
- Reset mid-command aborts immediately. No done pulse. sr_clk returns to 1; any resulting rising edge is harmless.
- sr_oe follows oe_en with one cycle latency in all non-reset states.
- States: IDLE, HI, LO, FIN.
- IDLE: cmd_ready=1, sr_clk=1. On cmd_valid at an edge: latch op, data, ser, and n. n=1 for load; min(cmd_cnt,SER_W) for shift.
  - If n=0: go to FIN, pulses=0.
  - Otherwise go to HI, pulses=0.
- HI (1 cycle): sr_clk=1. sr_mode=1 for load, 0 for shift. sr_in=latched data; held during shift and not relevant there. sr_ser=current pattern bit. Next state LO.
- LO (1 cycle): sr_clk=0, which gives the register its falling edge. mode, ser and in stay unchanged from HI. pulses increments. Pattern shifts right by one.
  - If pulses reaches n: go to FIN.
  - Otherwise go to HI.
- FIN (1 cycle): sr_clk=1, done=1, busy=1. Then go to IDLE.
- Timing: each pulse takes 2 cycles. A command with n pulses is busy for 2n+1 cycles after the accept edge. A command with n=0 is busy for 1 cycle. cmd_ready drops the cycle after accept.
- Back-to-back: a command offered while busy is held off (cmd_ready=0). It is accepted on the first IDLE cycle.
- sr_mode, sr_ser and sr_in change only on the transition into HI, never while sr_clk=0.
- cmd_cnt greater than SER_W is clamped. pulses holds its value in IDLE until the next accept.

Test Plan:
- Reset: assert rst 2 cycles mid-shift (n=5, after 2 pulses) -> next cycle sr_clk=1, sr_oe=0, busy=0, no done; then load 4'hA is accepted normally.
- Load: cmd_op=0, cmd_data=4'h9, oe_en=1 -> exactly one sr_clk high-to-low with sr_mode=1, sr_in=9; done 3 cycles after accept; register model q=4'h9.
- Shift: after loading 4'h9, shift cmd_cnt=4, cmd_ser=8'b0000_0110 -> 4 falling edges, sr_ser sequence 0,1,1,0; register q=4'h6; pulses=4; busy 9 cycles.
- Boundaries: cmd_cnt=0 -> done 1 cycle after accept with no sr_clk edge. cmd_cnt=15 with SER_W=8 -> exactly 8 falling edges.
- Handshake: cmd_valid held high continuously with alternating load/shift commands -> cmd_ready=1 only in IDLE; no command lost or duplicated; sr_mode/sr_ser stable in every cycle with sr_clk=0.
- OE: toggle oe_en during a shift -> sr_oe follows with 1-cycle latency; shift sequence unaffected.
